step_cmd_queue: RTL and testbench

Command queue and issue sequencer placed directly upstream of the step-pulse tick generator. Host logic pushes motion segments {direction, step count, tick period}. The block stores them in a small FIFO and issues them one at a time over the generator's trig/ready handshake, so back-to-back segments run with no host polling. Segments the generator would silently ignore are rejected at write time, which keeps the handshake from deadlocking.

---
 rtl/step_cmd_queue.sv | 221 ++++++++++++++++++++++
 tb/tb_step_cmd_queue.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module   : step_cmd_queue
// Brief    : Segment FIFO and one-at-a-time issue sequencer feeding the
//            step-pulse tick generator over a trig/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module step_cmd_queue #(
    parameter int DEPTH       = 8,
    parameter int AW          = 3,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_en_i,
    input  logic [15:0]   wr_step_i,
    input  logic [15:0]   wr_delay_i,
    input  logic          wr_dir_i,
    input  logic          flush_i,
    input  logic          pause_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o,
    output logic          wr_err_o,
    output logic [15:0]   step_o,
    output logic [15:0]   delay_o,
    output logic          dir_o,
    output logic          trig_o,
    input  logic          ready_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          ack_err_o
);

    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_ACK  = 2'd1;
    localparam logic [1:0]  S_RUN  = 2'd2;

    localparam logic [AW:0] c_depth    = (AW+1)'(DEPTH);
    localparam logic [3:0]  c_ack_last = 4'(ACK_TIMEOUT - 1);

    logic [32:0]   mem_q [DEPTH];

    logic [1:0]    state_q,   state_d;
    logic [AW-1:0] wr_ptr_q,  wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,  rd_ptr_d;
    logic [AW:0]   count_q,   count_d;
    logic          full_q,    full_d;
    logic          empty_q,   empty_d;
    logic [3:0]    timer_q,   timer_d;
    logic [15:0]   step_q,    step_d;
    logic [15:0]   delay_q,   delay_d;
    logic          dir_q,     dir_d;
    logic          trig_q,    trig_d;
    logic          busy_q,    busy_d;
    logic          done_q,    done_d;
    logic          wr_err_q,  wr_err_d;
    logic          ack_err_q, ack_err_d;

    logic          w_push_ok;
    logic          w_wr_bad;
    logic          w_pop;

    // Full is judged on the registered occupancy, so a pop on the same edge
    // never frees room for a push.
    always_comb begin
        w_push_ok = wr_en_i && !full_q && (wr_step_i != 16'd0)
                    && (wr_delay_i >= 16'd2) && !flush_i;
        w_wr_bad  = wr_en_i && !flush_i && !w_push_ok;
        w_pop     = (state_q == S_IDLE) && !empty_q && ready_i
                    && !pause_i && !flush_i;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
        full_d  = (count_d == c_depth);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk_i) begin
        if (w_push_ok) begin
            mem_q[wr_ptr_q] <= {wr_dir_i, wr_step_i, wr_delay_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_pop) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (!ready_i) begin
                    state_d = S_RUN;
                end else if (timer_q == c_ack_last) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        trig_d    = 1'b0;
        done_d    = 1'b0;
        ack_err_d = 1'b0;
        wr_err_d  = w_wr_bad;
        busy_d    = busy_q;
        step_d    = step_q;
        delay_d   = delay_q;
        dir_d     = dir_q;
        timer_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (w_pop) begin
                    trig_d                   = 1'b1;
                    busy_d                   = 1'b1;
                    {dir_d, step_d, delay_d} = mem_q[rd_ptr_q];
                end
            end
            S_ACK: begin
                timer_d = timer_q + 4'd1;
                if (ready_i && (timer_q == c_ack_last)) begin
                    ack_err_d = 1'b1;
                    busy_d    = 1'b0;
                end
            end
            S_RUN: begin
                if (ready_i) begin
                    busy_d = 1'b0;
                    done_d = (count_q == '0) && !w_push_ok;
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            timer_q   <= '0;
            step_q    <= 16'd0;
            delay_q   <= 16'd0;
            dir_q     <= 1'b1;
            trig_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_err_q  <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            timer_q   <= timer_d;
            step_q    <= step_d;
            delay_q   <= delay_d;
            dir_q     <= dir_d;
            trig_q    <= trig_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wr_err_q  <= wr_err_d;
            ack_err_q <= ack_err_d;
        end
    end

    assign full_o    = full_q;
    assign empty_o   = empty_q;
    assign count_o   = count_q;
    assign wr_err_o  = wr_err_q;
    assign step_o    = step_q;
    assign delay_o   = delay_q;
    assign dir_o     = dir_q;
    assign trig_o    = trig_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign ack_err_o = ack_err_q;

endmodule
`default_nettype wire

// File: tb/tb_step_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_step_cmd_queue
// Brief    : Self-checking bench for step_cmd_queue with a generator model and
//            a queue-based reference of the issue sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_step_cmd_queue;

    localparam int DEPTH       = 8;
    localparam int AW          = 3;
    localparam int ACK_TIMEOUT = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        wr_en_i;
    logic [15:0] wr_step_i;
    logic [15:0] wr_delay_i;
    logic        wr_dir_i;
    logic        flush_i;
    logic        pause_i;
    logic        full_o;
    logic        empty_o;
    logic [AW:0] count_o;
    logic        wr_err_o;
    logic [15:0] step_o;
    logic [15:0] delay_o;
    logic        dir_o;
    logic        trig_o;
    logic        ready_i = 1'b1;
    logic        busy_o;
    logic        done_o;
    logic        ack_err_o;

    step_cmd_queue #(.DEPTH(DEPTH), .AW(AW), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .wr_en_i(wr_en_i), .wr_step_i(wr_step_i),
        .wr_delay_i(wr_delay_i), .wr_dir_i(wr_dir_i), .flush_i(flush_i),
        .pause_i(pause_i), .full_o(full_o), .empty_o(empty_o), .count_o(count_o),
        .wr_err_o(wr_err_o), .step_o(step_o), .delay_o(delay_o), .dir_o(dir_o),
        .trig_o(trig_o), .ready_i(ready_i), .busy_o(busy_o), .done_o(done_o),
        .ack_err_o(ack_err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #3;
    endtask

    // Generator model: drops ready one cycle after seeing trig, runs, then idles.
    int gen_len       = 3;
    bit gen_noack     = 1'b0;
    bit gen_rand      = 1'b0;
    bit gen_force_low = 1'b0;
    int g_phase       = 0;
    int g_cnt         = 0;
    int g_wait        = 0;

    always @(posedge clk_i) begin : gen_proc
        bit seen;
        bit skip;
        seen = (trig_o === 1'b1);
        #2;
        if (gen_force_low) begin
            ready_i = 1'b0;
            g_phase = 3;
        end else begin
            case (g_phase)
                3: begin
                    ready_i = 1'b1;
                    g_phase = 0;
                end
                0: begin
                    skip = gen_noack || (gen_rand && ($urandom_range(0, 9) == 0));
                    if (seen && !skip) begin
                        g_cnt  = gen_rand ? int'($urandom_range(1, 4)) : gen_len;
                        g_wait = (gen_rand && ($urandom_range(0, 3) == 0))
                                 ? int'($urandom_range(1, 3)) : 0;
                        if (g_wait == 0) begin
                            ready_i = 1'b0;
                            g_phase = 2;
                        end else begin
                            g_phase = 1;
                        end
                    end
                end
                1: begin
                    g_wait--;
                    if (g_wait == 0) begin
                        ready_i = 1'b0;
                        g_phase = 2;
                    end
                end
                default: begin
                    g_cnt--;
                    if (g_cnt <= 0) begin
                        ready_i = 1'b1;
                        g_phase = 0;
                    end
                end
            endcase
        end
    end

    // Reference: a queue of pending segments plus the in-flight segment's status.
    typedef struct packed {
        logic        dir;
        logic [15:0] step;
        logic [15:0] delay;
    } seg_t;

    seg_t        mq[$];
    bit          m_valid = 1'b0;
    bit          m_busy;
    bit          m_acked;
    int          m_age;
    logic        e_werr, e_trig, e_done, e_ack, e_dir;
    logic [15:0] e_step, e_delay;

    always @(posedge clk_i) begin : model_proc
        int pre_n;
        bit accept;
        bit reject;
        bit issue;
        if (rst_i) begin
            mq.delete();
            m_busy  = 1'b0;
            m_acked = 1'b0;
            m_age   = 0;
            e_werr  = 1'b0;
            e_trig  = 1'b0;
            e_done  = 1'b0;
            e_ack   = 1'b0;
            e_dir   = 1'b1;
            e_step  = 16'd0;
            e_delay = 16'd0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            pre_n  = mq.size();
            accept = wr_en_i && (pre_n < DEPTH) && (wr_step_i != 0)
                     && (wr_delay_i >= 2) && !flush_i;
            reject = wr_en_i && !flush_i && !accept;
            issue  = !m_busy && (pre_n > 0) && ready_i && !pause_i && !flush_i;
            e_werr = reject;
            e_trig = 1'b0;
            e_done = 1'b0;
            e_ack  = 1'b0;
            if (m_busy) begin
                if (!m_acked) begin
                    if (!ready_i) begin
                        m_acked = 1'b1;
                    end else begin
                        m_age++;
                        if (m_age >= ACK_TIMEOUT) begin
                            m_busy = 1'b0;
                            e_ack  = 1'b1;
                        end
                    end
                end else if (ready_i) begin
                    m_busy = 1'b0;
                    e_done = (pre_n == 0) && !accept;
                end
            end else if (issue) begin
                e_trig                   = 1'b1;
                {e_dir, e_step, e_delay} = mq[0];
                m_busy                   = 1'b1;
                m_acked                  = 1'b0;
                m_age                    = 0;
            end
            if (flush_i) begin
                mq.delete();
            end else begin
                if (issue) begin
                    void'(mq.pop_front());
                end
                if (accept) begin
                    mq.push_back({wr_dir_i, wr_step_i, wr_delay_i});
                end
            end
        end
    end

    always @(posedge clk_i) begin : cmp_proc
        logic [43:0] act;
        logic [43:0] expv;
        #1;
        if (m_valid) begin
            act  = {full_o, empty_o, count_o, wr_err_o, trig_o, busy_o, done_o,
                    ack_err_o, dir_o, step_o, delay_o};
            expv = {mq.size() == DEPTH, mq.size() == 0, 4'(mq.size()), e_werr,
                    e_trig, m_busy, e_done, e_ack, e_dir, e_step, e_delay};
            n_cmp++;
            if (act !== expv) begin
                n_fail++;
                $display("FAIL cycle t=%0t got {full,empty,cnt,werr,trig,busy,done,ackerr,dir,step,delay}=%0b %0b %0d %0b %0b %0b %0b %0b %0b %0d %0d expected %0b %0b %0d %0b %0b %0b %0b %0b %0b %0d %0d",
                         $time, act[43], act[42], act[41:38], act[37], act[36], act[35],
                         act[34], act[33], act[32], act[31:16], act[15:0],
                         expv[43], expv[42], expv[41:38], expv[37], expv[36], expv[35],
                         expv[34], expv[33], expv[32], expv[31:16], expv[15:0]);
            end
        end
    end

    task automatic push(input int st, input int dl, input bit dr);
        wr_en_i    = 1'b1;
        wr_step_i  = 16'(st);
        wr_delay_i = 16'(dl);
        wr_dir_i   = dr;
        tick();
        wr_en_i    = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget && !(!busy_o && empty_o && ready_i); i++) begin
            tick();
        end
        chk("idle_reached", {31'd0, (!busy_o && empty_o && ready_i)}, 32'd1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int ntrig;
        int ndone;
        int done_trigs;
        int cnt;
        bit saw;
        rst_i      = 1'b1;
        wr_en_i    = 1'b0;
        wr_step_i  = 16'd0;
        wr_delay_i = 16'd0;
        wr_dir_i   = 1'b0;
        flush_i    = 1'b0;
        pause_i    = 1'b0;
        repeat (3) tick();
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_empty", 32'(empty_o), 32'd1);
        chk("rst_dir", 32'(dir_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        rst_i = 1'b0;
        tick();

        // Single segment round trip
        push(3, 4, 1'b1);
        chk("t1_count_after_push", 32'(count_o), 32'd1);
        chk("t1_no_bypass", 32'(trig_o), 32'd0);
        tick();
        chk("t1_trig", 32'(trig_o), 32'd1);
        chk("t1_step", 32'(step_o), 32'd3);
        chk("t1_delay", 32'(delay_o), 32'd4);
        chk("t1_dir", 32'(dir_o), 32'd1);
        chk("t1_busy", 32'(busy_o), 32'd1);
        tick();
        chk("t1_trig_width", 32'(trig_o), 32'd0);
        for (int i = 0; i < 20 && !done_o; i++) begin
            tick();
        end
        chk("t1_done", 32'(done_o), 32'd1);
        chk("t1_busy_released", 32'(busy_o), 32'd0);
        chk("t1_count_zero", 32'(count_o), 32'd0);

        // Fill while paused, overflow, then drain in order
        wait_idle(40);
        pause_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push(i + 1, 2 + i, i[0]);
        end
        chk("t2_full", 32'(full_o), 32'd1);
        chk("t2_count8", 32'(count_o), 32'd8);
        push(100, 10, 1'b0);
        chk("t2_overflow_err", 32'(wr_err_o), 32'd1);
        chk("t2_count_held", 32'(count_o), 32'd8);
        pause_i    = 1'b0;
        ntrig      = 0;
        ndone      = 0;
        done_trigs = -1;
        for (int c = 0; c < 300 && ndone == 0; c++) begin
            tick();
            if (trig_o) begin
                chk("t2_order", 32'(step_o), 32'(ntrig + 1));
                ntrig++;
            end
            if (done_o) begin
                ndone++;
                done_trigs = ntrig;
            end
        end
        chk("t2_trigs", 32'(ntrig), 32'd8);
        chk("t2_done_after_8th", 32'(done_trigs), 32'd8);

        // Illegal segments
        wait_idle(40);
        push(0, 5, 1'b0);
        chk("t3_step0_err", 32'(wr_err_o), 32'd1);
        chk("t3_step0_cnt", 32'(count_o), 32'd0);
        push(7, 1, 1'b0);
        chk("t3_delay1_err", 32'(wr_err_o), 32'd1);
        push(7, 0, 1'b0);
        chk("t3_delay0_err", 32'(wr_err_o), 32'd1);
        chk("t3_cnt", 32'(count_o), 32'd0);
        saw = 1'b0;
        repeat (6) begin
            tick();
            if (trig_o) saw = 1'b1;
        end
        chk("t3_no_trig", 32'(saw), 32'd0);

        // Flush during the first segment's run
        gen_len = 8;
        pause_i = 1'b1;
        push(11, 2, 1'b0);
        push(12, 3, 1'b1);
        push(13, 4, 1'b0);
        pause_i = 1'b0;
        for (int i = 0; i < 20 && !(busy_o && !ready_i); i++) begin
            tick();
        end
        chk("t4_running", {31'd0, (busy_o && !ready_i)}, 32'd1);
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("t4_flush_count", 32'(count_o), 32'd0);
        chk("t4_flush_empty", 32'(empty_o), 32'd1);
        for (int i = 0; i < 30 && !done_o; i++) begin
            tick();
        end
        chk("t4_done", 32'(done_o), 32'd1);
        saw = 1'b0;
        repeat (10) begin
            tick();
            if (trig_o) saw = 1'b1;
        end
        chk("t4_no_more_trig", 32'(saw), 32'd0);

        // Unacknowledged issue times out, next segment still issues
        gen_len   = 3;
        wait_idle(40);
        gen_noack = 1'b1;
        pause_i   = 1'b1;
        push(21, 5, 1'b0);
        push(22, 6, 1'b1);
        pause_i = 1'b0;
        for (int i = 0; i < 10 && !trig_o; i++) begin
            tick();
        end
        chk("t5_trig", 32'(trig_o), 32'd1);
        cnt = 0;
        for (int i = 0; i < 20 && !ack_err_o; i++) begin
            tick();
            cnt++;
        end
        chk("t5_ack_gap", 32'(cnt), 32'(ACK_TIMEOUT));
        chk("t5_busy_dropped", 32'(busy_o), 32'd0);
        gen_noack = 1'b0;
        for (int i = 0; i < 5 && !trig_o; i++) begin
            tick();
        end
        chk("t5_next_trig", 32'(trig_o), 32'd1);
        chk("t5_next_step", 32'(step_o), 32'd22);

        // Reset in the middle of a run
        wait_idle(40);
        gen_len = 10;
        push(31, 3, 1'b0);
        for (int i = 0; i < 15 && !(busy_o && !ready_i); i++) begin
            tick();
        end
        tick();
        gen_force_low = 1'b1;
        rst_i         = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("t6_rst_busy", 32'(busy_o), 32'd0);
        chk("t6_rst_trig", 32'(trig_o), 32'd0);
        chk("t6_rst_count", 32'(count_o), 32'd0);
        chk("t6_rst_step", 32'(step_o), 32'd0);
        chk("t6_rst_delay", 32'(delay_o), 32'd0);
        chk("t6_rst_dir", 32'(dir_o), 32'd1);
        push(32, 4, 1'b1);
        chk("t6_count", 32'(count_o), 32'd1);
        saw = 1'b0;
        repeat (4) begin
            tick();
            if (trig_o) saw = 1'b1;
        end
        chk("t6_no_trig_while_low", 32'(saw), 32'd0);
        gen_force_low = 1'b0;
        tick();
        chk("t6_trig_not_yet", 32'(trig_o), 32'd0);
        tick();
        chk("t6_trig_after_ready", 32'(trig_o), 32'd1);
        chk("t6_step", 32'(step_o), 32'd32);

        // Randomized traffic
        gen_len = 3;
        wait_idle(40);
        gen_rand = 1'b1;
        for (int c = 0; c < 600; c++) begin
            wr_en_i    = 1'($urandom_range(0, 1));
            wr_step_i  = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
            wr_delay_i = 16'($urandom_range(0, 6));
            wr_dir_i   = 1'($urandom_range(0, 1));
            flush_i    = ($urandom_range(0, 39) == 0);
            pause_i    = ($urandom_range(0, 5) == 0);
            tick();
        end
        wr_en_i  = 1'b0;
        flush_i  = 1'b0;
        pause_i  = 1'b0;
        gen_rand = 1'b0;
        wait_idle(400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
